// File: rtl/adjust_mode_controller.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// adjust_mode_controller
//
// Button-driven sequencer for the alarm clock. It sequences the NORMAL, ADJUST
// and RINGING modes, turns up/down presses into inc/dec strobes for the clock
// hour/minute counters, and holds the alarm hour/minute registers.
//
// Ports
//   clock        system clock, rising edge
//   rst          asynchronous, active-high reset
//   btn_c/u/d/l/r one-cycle button pulses (centre/up/down/left/right)
//   alarm_match  level, high while current time equals alarm time
//   adjust_mode  1 while in ADJUST
//   sel          field being adjusted (0 clk hr, 1 clk min, 2 alarm hr, 3 alarm min)
//   sel_led      one-hot of sel while in ADJUST, else 0
//   clk_hr_inc/dec, clk_min_inc/dec  one-cycle strobes to the clock counters
//   alarm_hr     alarm hour register   (0..HOURS-1)
//   alarm_min    alarm minute register (0..MINUTES-1)
//   alarm_en     alarm armed flag
//   ringing      1 while in RINGING
//   dbg_state    current FSM state (0 NORMAL, 1 ADJUST, 2 RINGING)
//
// Every output comes straight from a flop. A pulse in cycle N is visible in
// cycle N+1. Same-cycle pulses resolve with priority C > L > R > U > D.
// -----------------------------------------------------------------------------
module adjust_mode_controller #(
  parameter int HOURS   = 24,
  parameter int MINUTES = 60
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       btn_c,
  input  logic       btn_u,
  input  logic       btn_d,
  input  logic       btn_l,
  input  logic       btn_r,
  input  logic       alarm_match,
  output logic       adjust_mode,
  output logic [1:0] sel,
  output logic [3:0] sel_led,
  output logic       clk_hr_inc,
  output logic       clk_hr_dec,
  output logic       clk_min_inc,
  output logic       clk_min_dec,
  output logic [4:0] alarm_hr,
  output logic [5:0] alarm_min,
  output logic       alarm_en,
  output logic       ringing,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    ST_NORMAL  = 2'd0,
    ST_ADJUST  = 2'd1,
    ST_RINGING = 2'd2
  } state_t;

  localparam logic [4:0] HR_MAX  = 5'(HOURS - 1);
  localparam logic [5:0] MIN_MAX = 6'(MINUTES - 1);

  // State and registered outputs
  state_t     r_state;
  logic [1:0] r_sel;
  logic [3:0] r_sel_led;
  logic       r_adjust_mode;
  logic       r_ringing;
  logic       r_hr_inc;
  logic       r_hr_dec;
  logic       r_min_inc;
  logic       r_min_dec;
  logic [4:0] r_alarm_hr;
  logic [5:0] r_alarm_min;
  logic       r_alarm_en;
  logic       r_silenced;

  // Next-state values
  state_t     w_state_nxt;
  logic [1:0] w_sel_nxt;
  logic [3:0] w_sel_led_nxt;
  logic       w_hr_inc_nxt;
  logic       w_hr_dec_nxt;
  logic       w_min_inc_nxt;
  logic       w_min_dec_nxt;
  logic [4:0] w_alarm_hr_nxt;
  logic [5:0] w_alarm_min_nxt;
  logic       w_alarm_en_nxt;
  logic       w_silenced_nxt;

  // Priority-resolved button actions: at most one is high per cycle.
  logic w_act_c;
  logic w_act_l;
  logic w_act_r;
  logic w_act_u;
  logic w_act_d;
  logic w_any_btn;

  assign w_act_c   = btn_c;
  assign w_act_l   = ~btn_c & btn_l;
  assign w_act_r   = ~btn_c & ~btn_l & btn_r;
  assign w_act_u   = ~btn_c & ~btn_l & ~btn_r & btn_u;
  assign w_act_d   = ~btn_c & ~btn_l & ~btn_r & ~btn_u & btn_d;
  assign w_any_btn = btn_c | btn_l | btn_r | btn_u | btn_d;

  always_comb begin
    w_state_nxt     = r_state;
    w_sel_nxt       = r_sel;
    w_hr_inc_nxt    = 1'b0;
    w_hr_dec_nxt    = 1'b0;
    w_min_inc_nxt   = 1'b0;
    w_min_dec_nxt   = 1'b0;
    w_alarm_hr_nxt  = r_alarm_hr;
    w_alarm_min_nxt = r_alarm_min;
    w_alarm_en_nxt  = r_alarm_en;
    w_silenced_nxt  = r_silenced;

    case (r_state)
      ST_NORMAL: begin
        if (w_act_c) begin
          w_state_nxt = ST_ADJUST;
          w_sel_nxt   = 2'd0;
        end else if (w_act_u) begin
          w_alarm_en_nxt = ~r_alarm_en;
        end else if (alarm_match && r_alarm_en && !r_silenced) begin
          w_state_nxt = ST_RINGING;
        end
      end

      ST_ADJUST: begin
        // sel is left as-is on exit so the display can keep showing it.
        if (w_act_c) begin
          w_state_nxt = ST_NORMAL;
        end else if (w_act_l) begin
          w_sel_nxt = r_sel - 2'd1;
        end else if (w_act_r) begin
          w_sel_nxt = r_sel + 2'd1;
        end else if (w_act_u || w_act_d) begin
          case (r_sel)
            2'd0: begin
              w_hr_inc_nxt = w_act_u;
              w_hr_dec_nxt = w_act_d;
            end
            2'd1: begin
              w_min_inc_nxt = w_act_u;
              w_min_dec_nxt = w_act_d;
            end
            2'd2: begin
              if (w_act_u) begin
                w_alarm_hr_nxt = (r_alarm_hr == HR_MAX) ? 5'd0 : r_alarm_hr + 5'd1;
              end else begin
                w_alarm_hr_nxt = (r_alarm_hr == 5'd0) ? HR_MAX : r_alarm_hr - 5'd1;
              end
            end
            default: begin
              if (w_act_u) begin
                w_alarm_min_nxt = (r_alarm_min == MIN_MAX) ? 6'd0 : r_alarm_min + 6'd1;
              end else begin
                w_alarm_min_nxt = (r_alarm_min == 6'd0) ? MIN_MAX : r_alarm_min - 6'd1;
              end
            end
          endcase
        end
      end

      ST_RINGING: begin
        // Any press only silences; it is not passed on as a normal action.
        if (w_any_btn) begin
          w_state_nxt    = ST_NORMAL;
          w_silenced_nxt = 1'b1;
        end else if (!alarm_match) begin
          w_state_nxt = ST_NORMAL;
        end
      end

      default: begin
        w_state_nxt = ST_NORMAL;
      end
    endcase

    // Once the match window ends, the next match may ring again.
    if (!alarm_match) begin
      w_silenced_nxt = 1'b0;
    end

    w_sel_led_nxt = (w_state_nxt == ST_ADJUST) ? (4'b0001 << w_sel_nxt) : 4'b0000;
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_state       <= ST_NORMAL;
      r_sel         <= 2'd0;
      r_sel_led     <= 4'b0000;
      r_adjust_mode <= 1'b0;
      r_ringing     <= 1'b0;
      r_hr_inc      <= 1'b0;
      r_hr_dec      <= 1'b0;
      r_min_inc     <= 1'b0;
      r_min_dec     <= 1'b0;
      r_alarm_hr    <= 5'd0;
      r_alarm_min   <= 6'd0;
      r_alarm_en    <= 1'b0;
      r_silenced    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_sel         <= w_sel_nxt;
      r_sel_led     <= w_sel_led_nxt;
      r_adjust_mode <= (w_state_nxt == ST_ADJUST);
      r_ringing     <= (w_state_nxt == ST_RINGING);
      r_hr_inc      <= w_hr_inc_nxt;
      r_hr_dec      <= w_hr_dec_nxt;
      r_min_inc     <= w_min_inc_nxt;
      r_min_dec     <= w_min_dec_nxt;
      r_alarm_hr    <= w_alarm_hr_nxt;
      r_alarm_min   <= w_alarm_min_nxt;
      r_alarm_en    <= w_alarm_en_nxt;
      r_silenced    <= w_silenced_nxt;
    end
  end

  assign adjust_mode = r_adjust_mode;
  assign sel         = r_sel;
  assign sel_led     = r_sel_led;
  assign clk_hr_inc  = r_hr_inc;
  assign clk_hr_dec  = r_hr_dec;
  assign clk_min_inc = r_min_inc;
  assign clk_min_dec = r_min_dec;
  assign alarm_hr    = r_alarm_hr;
  assign alarm_min   = r_alarm_min;
  assign alarm_en    = r_alarm_en;
  assign ringing     = r_ringing;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_adjust_mode_controller.sv
`timescale 1ns/1ps
// Directed bench for adjust_mode_controller. Inputs change on the falling
// edge; outputs are compared on the following falling edge against the
// expected output vector queued when the stimulus was applied.
module tb_adjust_mode_controller;

  // ---------------- clock / reset ----------------
  logic       clock = 1'b0;
  logic       rst;
  logic       btn_c, btn_u, btn_d, btn_l, btn_r;
  logic       alarm_match;
  logic       adjust_mode;
  logic [1:0] sel;
  logic [3:0] sel_led;
  logic       clk_hr_inc, clk_hr_dec, clk_min_inc, clk_min_dec;
  logic [4:0] alarm_hr;
  logic [5:0] alarm_min;
  logic       alarm_en;
  logic       ringing;
  logic [1:0] dbg_state;

  always #5 clock = ~clock;

  adjust_mode_controller #(.HOURS(24), .MINUTES(60)) dut (
    .clock       (clock),
    .rst         (rst),
    .btn_c       (btn_c),
    .btn_u       (btn_u),
    .btn_d       (btn_d),
    .btn_l       (btn_l),
    .btn_r       (btn_r),
    .alarm_match (alarm_match),
    .adjust_mode (adjust_mode),
    .sel         (sel),
    .sel_led     (sel_led),
    .clk_hr_inc  (clk_hr_inc),
    .clk_hr_dec  (clk_hr_dec),
    .clk_min_inc (clk_min_inc),
    .clk_min_dec (clk_min_dec),
    .alarm_hr    (alarm_hr),
    .alarm_min   (alarm_min),
    .alarm_en    (alarm_en),
    .ringing     (ringing),
    .dbg_state   (dbg_state)
  );

  // Button vectors ordered {c, u, d, l, r}
  localparam logic [4:0] B_0 = 5'b00000;
  localparam logic [4:0] B_C = 5'b10000;
  localparam logic [4:0] B_U = 5'b01000;
  localparam logic [4:0] B_D = 5'b00100;
  localparam logic [4:0] B_L = 5'b00010;
  localparam logic [4:0] B_R = 5'b00001;

  localparam int W = 24;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // Expected output fields, updated by hand at each directed step.
  logic       e_adj, e_hr_inc, e_hr_dec, e_min_inc, e_min_dec, e_en, e_ring;
  logic [1:0] e_sel;
  logic [4:0] e_ahr;
  logic [5:0] e_amin;

  function automatic logic [W-1:0] pack_exp();
    logic [3:0] led;
    led = e_adj ? (4'b0001 << e_sel) : 4'b0000;
    return {e_adj, e_sel, led, e_hr_inc, e_hr_dec, e_min_inc, e_min_dec,
            e_ahr, e_amin, e_en, e_ring};
  endfunction

  function automatic logic [W-1:0] pack_obs();
    return {adjust_mode, sel, sel_led, clk_hr_inc, clk_hr_dec, clk_min_inc,
            clk_min_dec, alarm_hr, alarm_min, alarm_en, ringing};
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_exp();
    e_adj = 0; e_sel = 0; e_hr_inc = 0; e_hr_dec = 0; e_min_inc = 0;
    e_min_dec = 0; e_ahr = 0; e_amin = 0; e_en = 0; e_ring = 0;
  endtask

  // ---------------- driver ----------------
  // Called on a falling edge: apply buttons/match for one cycle, queue the
  // expected outputs, then compare on the next falling edge.
  task automatic step(input string tag, input logic [4:0] b, input logic m);
    {btn_c, btn_u, btn_d, btn_l, btn_r} = b;
    alarm_match = m;
    exp_q.push_back(pack_exp());
    @(negedge clock);
    {btn_c, btn_u, btn_d, btn_l, btn_r} = B_0;
    check(tag, pack_obs(), exp_q.pop_front());
    e_hr_inc = 0; e_hr_dec = 0; e_min_inc = 0; e_min_dec = 0;
  endtask

  // Compare the current outputs without advancing the clock.
  task automatic sample(input string tag);
    exp_q.push_back(pack_exp());
    check(tag, pack_obs(), exp_q.pop_front());
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    {btn_c, btn_u, btn_d, btn_l, btn_r} = B_0;
    alarm_match = 1'b0;
    clear_exp();
    @(negedge clock);
    @(negedge clock);
    rst = 1'b0;
    sample("reset_state");

    // Selector navigation
    e_adj = 1; e_sel = 0;           step("enter_adjust", B_C, 0);
    e_sel = 3;                      step("sel_left_wrap", B_L, 0);
    e_sel = 0;                      step("sel_right_wrap", B_R, 0);

    // Clock strobes
    e_hr_inc = 1;                   step("hr_inc_strobe", B_U, 0);
                                    step("hr_inc_one_cycle", B_0, 0);
    e_sel = 1;                      step("sel_to_min", B_R, 0);
    e_min_dec = 1;                  step("min_dec_strobe", B_D, 0);
                                    step("min_dec_one_cycle", B_0, 0);
    e_min_inc = 1;                  step("u_beats_d", B_U | B_D, 0);
                                    step("min_inc_one_cycle", B_0, 0);

    // Alarm hour wrap
    e_sel = 2;                      step("sel_to_alarm_hr", B_R, 0);
    e_ahr = 5'd23;                  step("alarm_hr_down_wrap", B_D, 0);
    e_ahr = 5'd0;                   step("alarm_hr_up_wrap", B_U, 0);
    e_ahr = 5'd23;                  step("alarm_hr_down_again", B_D, 0);

    // Alarm minute wrap
    e_sel = 3;                      step("sel_to_alarm_min", B_R, 0);
    e_amin = 6'd59;                 step("alarm_min_down_wrap", B_D, 0);
    e_amin = 6'd0;                  step("alarm_min_up_wrap", B_U, 0);
    e_amin = 6'd59;                 step("alarm_min_down_again", B_D, 0);
    e_adj = 0;                      step("c_beats_u_exit", B_C | B_U, 0);

    // Arm, ring, silence, re-ring
    e_en = 1;                       step("arm_alarm", B_U, 0);
    e_ring = 1;                     step("ring_start", B_0, 1);
    e_ring = 0;                     step("silence_by_r", B_R, 1);
                                    step("silenced_hold_1", B_0, 1);
                                    step("silenced_hold_2", B_0, 1);
                                    step("match_drop", B_0, 0);
    e_ring = 1;                     step("re_ring", B_0, 1);
    e_ring = 0;                     step("auto_stop", B_0, 0);

    // No ringing while adjusting
    e_adj = 1; e_sel = 0;           step("adjust_again", B_C, 0);
                                    step("adjust_match_no_ring", B_0, 1);
                                    step("adjust_match_hold", B_0, 1);
    e_adj = 0;                      step("leave_adjust", B_C, 1);
    e_ring = 1;                     step("ring_after_adjust", B_0, 1);
    e_ring = 0;                     step("auto_stop_2", B_0, 0);

    // Disarmed: no ring
    e_en = 0;                       step("disarm", B_U, 0);
                                    step("disarmed_match_1", B_0, 1);
                                    step("disarmed_match_2", B_0, 1);
                                    step("disarmed_drop", B_0, 0);

    // Asynchronous reset while ringing
    e_en = 1;                       step("rearm", B_U, 0);
    e_ring = 1;                     step("ring_before_reset", B_0, 1);
    #2 rst = 1'b1;
    #1 clear_exp();
    sample("async_reset_mid_ring");
    @(negedge clock);
    rst = 1'b0;
                                    step("post_reset_idle", B_0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
